// File: rtl/mem_berger_scrub.sv
// mem_berger_scrub: single-port register-file memory protected by a Berger
// zero-count code, with a registered read port, a background scrubber and a
// saturating error counter. It detects errors only and never corrects them.
module mem_berger_scrub #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic                                    rd_en,
  input  logic [ADDR_W-1:0]                       addr,
  input  logic [DATA_W-1:0]                       data_in,
  input  logic [DATA_W+$clog2(DATA_W+1)-1:0]      inj_mask,
  input  logic                                    scrub_en,
  output logic [DATA_W-1:0]                       data_out,
  output logic                                    rd_valid,
  output logic                                    rd_err,
  output logic                                    scrub_err,
  output logic [ADDR_W-1:0]                       scrub_err_addr,
  output logic                                    scrub_busy,
  output logic [CNT_W-1:0]                        err_count
);
  localparam int CHK_W  = $clog2(DATA_W+1);
  localparam int WORD_W = DATA_W + CHK_W;
  localparam int DEPTH  = 2**ADDR_W;

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  // Berger check: number of zero bits in the data field.
  function automatic logic [CHK_W-1:0] zeros(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_W; i++) n = n + CHK_W'(!d[i]);
    return n;
  endfunction

  logic [WORD_W-1:0] mem_q [DEPTH];
  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q, err_addr_q;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_err_q, rd_err_d, scrub_err_q;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic [WORD_W-1:0] rd_word, sc_word;
  logic              rd_bad, sc_bad, scrub_go, scrub_hit;
  logic [CNT_W:0]    cnt_sum;

  // Storage: reset loads {chk=DATA_W, data=0}, a valid codeword; writes
  // store the encoded word with the optional fault mask applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {CHK_W'(DATA_W), DATA_W'(0)};
    end else if (wr_en) begin
      mem_q[addr] <= {zeros(data_in), data_in} ^ inj_mask;
    end
  end

  // Code checks for the host port and the scrub pointer, plus next-state
  // values for the read port and the error counter.
  always_comb begin
    rd_word    = mem_q[addr];
    sc_word    = mem_q[ptr_q];
    rd_bad     = zeros(rd_word[DATA_W-1:0]) != rd_word[WORD_W-1:DATA_W];
    sc_bad     = zeros(sc_word[DATA_W-1:0]) != sc_word[WORD_W-1:DATA_W];
    // Host access owns the cycle; the scrubber only advances on idle cycles.
    scrub_go   = (state_q == S_SCAN) && scrub_en && !wr_en && !rd_en;
    scrub_hit  = scrub_go && sc_bad;
    data_out_d = rd_en ? rd_word[DATA_W-1:0] : data_out_q;
    rd_err_d   = rd_en && rd_bad;
    // One extra bit catches overflow when both sources fire at the top of the range.
    cnt_sum    = {1'b0, err_count_q} + (CNT_W+1)'(rd_err_d) + (CNT_W+1)'(scrub_hit);
    err_count_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // Registered read port and the saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      err_count_q <= '0;
    end else begin
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_en;
      rd_err_q    <= rd_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Scrub FSM: walks the pointer across all words while enabled and idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      err_addr_q  <= '0;
      scrub_err_q <= 1'b0;
    end else begin
      scrub_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (scrub_en) state_q <= S_SCAN;
        S_SCAN: begin
          if (!scrub_en) begin
            state_q <= S_IDLE;
          end else if (scrub_go) begin
            ptr_q <= ptr_q + 1'b1;
            if (scrub_hit) begin
              scrub_err_q <= 1'b1;
              err_addr_q  <= ptr_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign rd_valid       = rd_valid_q;
  assign rd_err         = rd_err_q;
  assign scrub_err      = scrub_err_q;
  assign scrub_err_addr = err_addr_q;
  assign scrub_busy     = (state_q == S_SCAN);
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_mem_berger_scrub.sv
// Directed bench for mem_berger_scrub: a main instance (CNT_W=8) and a narrow
// counter instance (CNT_W=2) share one stimulus stream.
module tb_mem_berger_scrub;
  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, scrub_en;
  logic [3:0]  addr;
  logic [7:0]  data_in;
  logic [11:0] inj_mask;

  logic [7:0]  data_out, s_data_out;
  logic        rd_valid, rd_err, scrub_err, scrub_busy;
  logic        s_rd_valid, s_rd_err, s_scrub_err, s_scrub_busy;
  logic [3:0]  scrub_err_addr, s_scrub_err_addr;
  logic [7:0]  err_count;
  logic [1:0]  s_err_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int exp_sat  = 0;

  always #5 clk = ~clk;

  mem_berger_scrub #(.DATA_W(8), .ADDR_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .data_in(data_in), .inj_mask(inj_mask), .scrub_en(scrub_en),
    .data_out(data_out), .rd_valid(rd_valid), .rd_err(rd_err),
    .scrub_err(scrub_err), .scrub_err_addr(scrub_err_addr),
    .scrub_busy(scrub_busy), .err_count(err_count));

  mem_berger_scrub #(.DATA_W(8), .ADDR_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .data_in(data_in), .inj_mask(inj_mask), .scrub_en(scrub_en),
    .data_out(s_data_out), .rd_valid(s_rd_valid), .rd_err(s_rd_err),
    .scrub_err(s_scrub_err), .scrub_err_addr(s_scrub_err_addr),
    .scrub_busy(s_scrub_busy), .err_count(s_err_count));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [11:0] m);
    wr_en = 1'b1; addr = a; data_in = d; inj_mask = m;
    step();
    wr_en = 1'b0; inj_mask = '0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; addr = a;
    step();
    rd_en = 1'b0;
  endtask

  task automatic cnt_err();
    exp_cnt = exp_cnt + 1;
    exp_sat = (exp_sat == 3) ? 3 : exp_sat + 1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt"}, 32'(err_count), 32'(exp_cnt));
    chk({tag, "_satcnt"}, 32'(s_err_count), 32'(exp_sat));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; scrub_en = 1'b0;
    addr = '0; data_in = '0; inj_mask = '0;
    step();
    rst = 1'b0;

    // T1: reset state and reset memory contents
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_busy", 32'(scrub_busy), 0);
    chk("rst_serr", 32'(scrub_err), 0);
    chk("rst_saddr", 32'(scrub_err_addr), 0);
    chk_cnt("rst");
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("t1_valid", 32'(rd_valid), 1);
      chk("t1_data", 32'(data_out), 32'h00);
      chk("t1_err", 32'(rd_err), 0);
    end
    chk_cnt("t1");

    // T2: clean write/read, hold behaviour, write+read same cycle
    wr(4'd3, 8'hA5, 12'h000);
    rd(4'd3);
    chk("t2_valid", 32'(rd_valid), 1);
    chk("t2_data", 32'(data_out), 32'hA5);
    chk("t2_err", 32'(rd_err), 0);
    step();
    chk("t2_pulse", 32'(rd_valid), 0);
    chk("t2_hold", 32'(data_out), 32'hA5);
    wr_en = 1'b1; rd_en = 1'b1; addr = 4'd3; data_in = 8'h3C;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t2_rw_old", 32'(data_out), 32'hA5);
    chk("t2_rw_valid", 32'(rd_valid), 1);
    rd(4'd3);
    chk("t2_rw_new", 32'(data_out), 32'h3C);
    chk("t2_rw_err", 32'(rd_err), 0);

    // T3: fault injection in data bits and check bits
    wr(4'd5, 8'hA5, 12'h002);
    rd(4'd5);
    cnt_err();
    chk("t3_data", 32'(data_out), 32'hA7);
    chk("t3_err", 32'(rd_err), 1);
    chk_cnt("t3");
    wr(4'd6, 8'hA5, 12'h100);
    rd(4'd6);
    cnt_err();
    chk("t3_chk_data", 32'(data_out), 32'hA5);
    chk("t3_chk_err", 32'(rd_err), 1);
    chk_cnt("t3_chk");
    // Balanced bidirectional flip (bit0 1->0, bit1 0->1) goes unnoticed.
    wr(4'd8, 8'hA5, 12'h003);
    rd(4'd8);
    chk("t3_bal_data", 32'(data_out), 32'hA6);
    chk("t3_bal_err", 32'(rd_err), 0);
    chk_cnt("t3_bal");

    // T5: repeated erroneous reads; the narrow counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      rd(4'd5);
      cnt_err();
      chk("t5_err", 32'(rd_err), 1);
      chk_cnt("t5");
    end
    step();
    chk_cnt("t5_idle");

    // Clean the injected words; all-ones word has zero check bits
    wr(4'd5, 8'h5A, 12'h000);
    wr(4'd6, 8'hFF, 12'h000);
    rd(4'd6);
    chk("fix_data", 32'(data_out), 32'hFF);
    chk("fix_err", 32'(rd_err), 0);
    rd(4'd5);
    chk("fix_err5", 32'(rd_err), 0);
    chk_cnt("fix");

    // T4: scrubber, one bad word at address 7
    wr(4'd7, 8'h00, 12'h001);
    scrub_en = 1'b1;
    step();
    chk("t4_busy", 32'(scrub_busy), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_p1_quiet", 32'(scrub_err), 0);
    end
    step();
    cnt_err();
    chk("t4_p1_pulse", 32'(scrub_err), 1);
    chk("t4_p1_addr", 32'(scrub_err_addr), 7);
    chk_cnt("t4_p1");
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t4_p2_quiet", 32'(scrub_err), 0);
    end
    step();
    cnt_err();
    chk("t4_p2_pulse", 32'(scrub_err), 1);
    chk("t4_p2_addr", 32'(scrub_err_addr), 7);
    chk_cnt("t4_p2");
    // Host read stalls the pointer for one cycle.
    rd(4'd2);
    chk("t4_stall_valid", 32'(rd_valid), 1);
    chk("t4_stall_err", 32'(rd_err), 0);
    chk("t4_stall_serr", 32'(scrub_err), 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t4_p3_quiet", 32'(scrub_err), 0);
    end
    step();
    cnt_err();
    chk("t4_p3_pulse", 32'(scrub_err), 1);
    chk("t4_p3_addr", 32'(scrub_err_addr), 7);
    chk_cnt("t4_p3");
    step();
    chk("t4_busy2", 32'(scrub_busy), 1);

    // T6: reset mid-scan
    rst = 1'b1; scrub_en = 1'b0;
    step();
    rst = 1'b0;
    exp_cnt = 0; exp_sat = 0;
    chk("t6_busy", 32'(scrub_busy), 0);
    chk("t6_serr", 32'(scrub_err), 0);
    chk("t6_saddr", 32'(scrub_err_addr), 0);
    chk_cnt("t6");
    rd(4'd7);
    chk("t6_data7", 32'(data_out), 32'h00);
    chk("t6_err7", 32'(rd_err), 0);
    rd(4'd3);
    chk("t6_data3", 32'(data_out), 32'h00);
    chk_cnt("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
